// File: rtl/rv_seq_divider.sv
// rtl/rv_seq_divider.sv - radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Optional build macro DIV_EARLY_TERM_EN enables small-operand shortcuts.
module rv_seq_divider #(
    parameter int N     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    state_t         state;
    logic [CNT_W-1:0] count;
    logic [N-1:0]   q;
    logic [N-1:0]   d;
    logic [N:0]     r;
    logic           rem_sel;
    logic           qneg;
    logic           rneg;

    logic           sgn_in;
    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic           ovf;
    logic [N:0]     rem_shift;
    logic [N:0]     trial;

    always_comb begin
        sgn_in    = ~op[0];
        a_neg     = sgn_in & dividend[N-1];
        b_neg     = sgn_in & divisor[N-1];
        mag_a     = a_neg ? ({N{1'b0}} - dividend) : dividend;
        mag_b     = b_neg ? ({N{1'b0}} - divisor) : divisor;
        ovf       = sgn_in && (dividend == MIN_NEG) && (divisor == {N{1'b1}});
        rem_shift = {r[N-1:0], q[N-1]};
        // Partial remainder stays below 2*D, so bit N of the difference is its sign.
        trial     = rem_shift - {1'b0, d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            count   <= '0;
            q       <= '0;
            d       <= '0;
            r       <= '0;
            rem_sel <= 1'b0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rem_sel <= op[1];
                        if (divisor == '0) begin
                            result <= op[1] ? dividend : {N{1'b1}};
                            done   <= 1'b1;
                        end else if (ovf) begin
                            result <= op[1] ? {N{1'b0}} : dividend;
                            done   <= 1'b1;
`ifdef DIV_EARLY_TERM_EN
                        end else if (mag_b > mag_a) begin
                            result <= op[1] ? dividend : {N{1'b0}};
                            done   <= 1'b1;
`endif
                        end else begin
                            d    <= mag_b;
                            r    <= '0;
                            qneg <= a_neg ^ b_neg;
                            rneg <= a_neg;
                            busy <= 1'b1;
                            state <= CALC;
`ifdef DIV_EARLY_TERM_EN
                            // Upper half of Q is zero: skip those iterations.
                            if (mag_a[N-1:N/2] == '0) begin
                                q     <= mag_a << (N/2);
                                count <= CNT_W'(N/2);
                            end else begin
                                q     <= mag_a;
                                count <= '0;
                            end
`else
                            q     <= mag_a;
                            count <= '0;
`endif
                        end
                    end
                end
                CALC: begin
                    if (!trial[N]) begin
                        r <= trial;
                        q <= {q[N-2:0], 1'b1};
                    end else begin
                        r <= rem_shift;
                        q <= {q[N-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CNT_W'(N-1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (rem_sel) begin
                        result <= rneg ? ({N{1'b0}} - r[N-1:0]) : r[N-1:0];
                    end else begin
                        result <= qneg ? ({N{1'b0}} - q) : q;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
